// File: rtl/mesh_pkg.sv
// Shared constants and helpers for the mesh row link fabric: channel numbering
// within a row and the width of a per-channel occupancy count.
package mesh_pkg;

  localparam int PACKET_WIDTH_DEF = 64;

  // Link k carries its clockwise flow on channel 2k and counter-clockwise on 2k+1.
  function automatic int cw_ch(input int k);
    return 2 * k;
  endfunction

  function automatic int ccw_ch(input int k);
    return 2 * k + 1;
  endfunction

  // Occupancy runs 0..DEPTH inclusive, hence one bit more than a pointer.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/link_fifo.sv
// One link channel: first-word-fall-through FIFO with a registered ready and
// full/empty derived from an occupancy counter.
module link_fifo
  import mesh_pkg::*;
#(
  parameter int PACKET_WIDTH = PACKET_WIDTH_DEF,
  parameter int DEPTH        = 4,
  localparam int PTR_W       = $clog2(DEPTH),
  localparam int LVL_W       = level_w(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic [PACKET_WIDTH-1:0] push_data,
  output logic                    ready,
  input  logic                    pop,
  output logic [PACKET_WIDTH-1:0] head_data,
  output logic                    empty,
  output logic [LVL_W-1:0]        level
);

  logic [PACKET_WIDTH-1:0] mem [DEPTH];
  logic [PACKET_WIDTH-1:0] hold_q;
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [LVL_W-1:0]        level_nxt;
  logic                    wr_en;
  logic                    rd_en;

  assign empty = (level == '0);
  // ready is a register, so a slot freed by a read is only offered from the next cycle.
  assign wr_en = push && ready;
  assign rd_en = pop && !empty;

  always_comb begin
    level_nxt = level;
    if (wr_en && !rd_en) begin
      level_nxt = level + LVL_W'(1);
    end else if (rd_en && !wr_en) begin
      level_nxt = level - LVL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ready  <= 1'b0;
      hold_q <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        hold_q <= mem[rd_ptr];
      end
      level <= level_nxt;
      ready <= (level_nxt != LVL_W'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // When empty, keep showing the last flit that left so the output never goes unknown.
  assign head_data = empty ? hold_q : mem[rd_ptr];

endmodule

// File: rtl/mesh_row_link_bank.sv
// Horizontal link fabric for one mesh row: a buffered channel in each direction on
// every internal link, with an optional even/odd gate on downstream sends.
module mesh_row_link_bank
  import mesh_pkg::*;
#(
  parameter int PACKET_WIDTH  = PACKET_WIDTH_DEF,
  parameter int NUM_COLS      = 4,
  parameter int DEPTH         = 4,
  parameter int GATE_POLARITY = 0,
  parameter int OUT_PHASE     = 0,
  localparam int NCH          = 2 * (NUM_COLS - 1),
  localparam int LVL_W        = level_w(DEPTH)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NCH-1:0]              in_si,
  input  logic [NCH*PACKET_WIDTH-1:0] in_di,
  output logic [NCH-1:0]              in_ri,
  output logic [NCH-1:0]              out_so,
  output logic [NCH*PACKET_WIDTH-1:0] out_do,
  input  logic [NCH-1:0]              out_ro,
  output logic [NCH*LVL_W-1:0]        level,
  output logic                        polarity
);

  logic           gate_open;
  logic [NCH-1:0] empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      polarity <= 1'b0;
    end else begin
      polarity <= ~polarity;
    end
  end

  // Sends depend only on registered state, never combinationally on in_si.
  assign gate_open = (GATE_POLARITY == 0) || (polarity == 1'(OUT_PHASE));
  assign out_so    = ~empty & {NCH{gate_open}};

  for (genvar k = 0; k < NUM_COLS - 1; k++) begin : g_link
    for (genvar d = 0; d < 2; d++) begin : g_dir
      localparam int CH = (d == 0) ? cw_ch(k) : ccw_ch(k);

      link_fifo #(
        .PACKET_WIDTH (PACKET_WIDTH),
        .DEPTH        (DEPTH)
      ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (in_si[CH]),
        .push_data (in_di[CH*PACKET_WIDTH +: PACKET_WIDTH]),
        .ready     (in_ri[CH]),
        .pop       (out_so[CH] && out_ro[CH]),
        .head_data (out_do[CH*PACKET_WIDTH +: PACKET_WIDTH]),
        .empty     (empty[CH]),
        .level     (level[CH*LVL_W +: LVL_W])
      );
    end
  end

endmodule

// File: tb/tb_mesh_row_link_bank.sv
// Bench for mesh_row_link_bank: an ungated 4-column row and a gated 2-column row
// driven side by side and compared every cycle against a queue-based model.
module tb_mesh_row_link_bank;

  localparam int PW    = 64;
  localparam int DEPTH = 4;
  localparam int LW    = 3;
  localparam int NCH0  = 6;
  localparam int NCH1  = 2;
  localparam int NI    = NCH0 + NCH1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  wire [NCH0-1:0]    si0, ri0, so0, ro0;
  wire [NCH0*PW-1:0] di0, do0;
  wire [NCH0*LW-1:0] lv0;
  wire               pol0;
  wire [NCH1-1:0]    si1, ri1, so1, ro1;
  wire [NCH1*PW-1:0] di1, do1;
  wire [NCH1*LW-1:0] lv1;
  wire               pol1;

  mesh_row_link_bank #(
    .PACKET_WIDTH(PW), .NUM_COLS(4), .DEPTH(DEPTH), .GATE_POLARITY(0), .OUT_PHASE(0)
  ) dut0 (
    .clk(clk), .reset(reset), .in_si(si0), .in_di(di0), .in_ri(ri0), .out_so(so0),
    .out_do(do0), .out_ro(ro0), .level(lv0), .polarity(pol0)
  );

  mesh_row_link_bank #(
    .PACKET_WIDTH(PW), .NUM_COLS(2), .DEPTH(DEPTH), .GATE_POLARITY(1), .OUT_PHASE(1)
  ) dut1 (
    .clk(clk), .reset(reset), .in_si(si1), .in_di(di1), .in_ri(ri1), .out_so(so1),
    .out_do(do1), .out_ro(ro1), .level(lv1), .polarity(pol1)
  );

  // Flat per-channel view: index 0..5 is dut0, 6..7 is dut1.
  logic          si [NI];
  logic [PW-1:0] di [NI];
  logic          ro [NI];
  wire           so_a [NI];
  wire           ri_a [NI];
  wire [PW-1:0]  do_a [NI];
  wire [LW-1:0]  lv_a [NI];

  for (genvar c = 0; c < NCH0; c++) begin : g_map0
    assign si0[c]            = si[c];
    assign di0[c*PW +: PW]   = di[c];
    assign ro0[c]            = ro[c];
    assign so_a[c]           = so0[c];
    assign ri_a[c]           = ri0[c];
    assign do_a[c]           = do0[c*PW +: PW];
    assign lv_a[c]           = lv0[c*LW +: LW];
  end
  for (genvar c = 0; c < NCH1; c++) begin : g_map1
    assign si1[c]            = si[NCH0+c];
    assign di1[c*PW +: PW]   = di[NCH0+c];
    assign ro1[c]            = ro[NCH0+c];
    assign so_a[NCH0+c]      = so1[c];
    assign ri_a[NCH0+c]      = ri1[c];
    assign do_a[NCH0+c]      = do1[c*PW +: PW];
    assign lv_a[NCH0+c]      = lv1[c*LW +: LW];
  end

  logic [PW-1:0] mq    [NI][$];
  logic [PW-1:0] src   [NI][$];
  logic [PW-1:0] exp_q [NI][$];
  logic [PW-1:0] rcv   [NI][$];
  logic [PW-1:0] mhold [NI];
  logic          mpol;
  logic          mrdy_on;
  int            ro_mode [NI];
  int            n_err = 0;
  int            n_chk = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic exp_so(input int i);
    if (mq[i].size() == 0) return 1'b0;
    if (i >= NCH0) return mpol;
    return 1'b1;
  endfunction

  function automatic logic exp_ri(input int i);
    return mrdy_on && (mq[i].size() < DEPTH);
  endfunction

  function automatic logic [PW-1:0] exp_do(input int i);
    return (mq[i].size() > 0) ? mq[i][0] : mhold[i];
  endfunction

  function automatic bit busy();
    for (int i = 0; i < NI; i++)
      if (src[i].size() > 0 || mq[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NI; i++) begin
      mq[i].delete();
      mhold[i] = '0;
    end
    mpol    = 1'b0;
    mrdy_on = 1'b0;
  endtask

  task automatic model_edge();
    logic acc, pop;
    if (!reset) begin
      model_clear();
    end else begin
      for (int i = 0; i < NI; i++) begin
        acc = si[i] && exp_ri(i);
        pop = exp_so(i) && ro[i];
        if (pop) mhold[i] = mq[i].pop_front();
        if (acc) begin
          mq[i].push_back(di[i]);
          void'(src[i].pop_front());
        end
      end
      mpol    = !mpol;
      mrdy_on = 1'b1;
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < NI; i++) begin
      si[i] = (src[i].size() > 0);
      di[i] = si[i] ? src[i][0] : {$urandom(), $urandom()};
      case (ro_mode[i])
        0:       ro[i] = 1'b0;
        1:       ro[i] = 1'b1;
        default: ro[i] = 1'($urandom_range(0, 1));
      endcase
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < NI; i++) begin
      check_val($sformatf("out_so[%0d]", i), 64'(so_a[i]), 64'(exp_so(i)));
      check_val($sformatf("in_ri[%0d]", i), 64'(ri_a[i]), 64'(exp_ri(i)));
      check_val($sformatf("level[%0d]", i), 64'(lv_a[i]), 64'(mq[i].size()));
      check_val($sformatf("out_do[%0d]", i), do_a[i], exp_do(i));
      if (so_a[i] && ro[i]) rcv[i].push_back(do_a[i]);
    end
    check_val("polarity0", 64'(pol0), 64'(mpol));
    check_val("polarity1", 64'(pol1), 64'(mpol));
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
    drive_inputs();
  endtask

  task automatic send(input int i, input logic [PW-1:0] v);
    src[i].push_back(v);
    exp_q[i].push_back(v);
  endtask

  task automatic run_drain(input int budget);
    int k;
    k = 0;
    while (k < budget && busy()) begin
      cycle();
      k++;
    end
  endtask

  task automatic compare_stream(input int i);
    int n;
    check_val($sformatf("stream_cnt[%0d]", i), 64'(rcv[i].size()), 64'(exp_q[i].size()));
    n = (rcv[i].size() < exp_q[i].size()) ? rcv[i].size() : exp_q[i].size();
    for (int k = 0; k < n; k++)
      check_val($sformatf("stream[%0d][%0d]", i, k), rcv[i][k], exp_q[i][k]);
    rcv[i].delete();
    exp_q[i].delete();
  endtask

  task automatic check_all_reset(input string tag);
    check_val({tag, "_so0"}, 64'(so0), 64'd0);
    check_val({tag, "_ri0"}, 64'(ri0), 64'd0);
    check_val({tag, "_lv0"}, 64'(lv0), 64'd0);
    check_val({tag, "_do0"}, 64'(|do0), 64'd0);
    check_val({tag, "_so1"}, 64'(so1), 64'd0);
    check_val({tag, "_lv1"}, 64'(lv1), 64'd0);
    check_val({tag, "_do1"}, 64'(|do1), 64'd0);
    check_val({tag, "_pol"}, 64'(pol0), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first_k, last_k, sz;
    for (int i = 0; i < NI; i++) ro_mode[i] = 1;
    #1 reset = 1'b0;
    model_clear();
    drive_inputs();

    // Reset held for three cycles, then released.
    repeat (3) cycle();
    check_all_reset("rst");
    reset = 1'b1;
    cycle();
    check_val("post_rst_ri0", 64'(ri0), 64'h3f);
    check_val("post_rst_ri1", 64'(ri1), 64'h3);

    // Single flit through channel 0.
    send(0, 64'hDEAD_BEEF_0000_0001);
    drive_inputs();
    cycle();
    check_val("single_so", 64'(so_a[0]), 64'd1);
    check_val("single_do", do_a[0], 64'hDEAD_BEEF_0000_0001);
    cycle();
    check_val("single_lvl", 64'(lv_a[0]), 64'd0);
    compare_stream(0);

    // Fill with backpressure: flit 5 must wait.
    ro_mode[2] = 0;
    for (int v = 1; v <= 5; v++) send(2, 64'(v));
    drive_inputs();
    repeat (6) cycle();
    check_val("bp_level", 64'(lv_a[2]), 64'd4);
    check_val("bp_ri", 64'(ri_a[2]), 64'd0);
    ro_mode[2] = 1;
    drive_inputs();
    run_drain(30);
    compare_stream(2);

    // Full with a simultaneous read and write attempt.
    ro_mode[3] = 0;
    for (int v = 0; v < 5; v++) send(3, 64'h30 + 64'(v));
    drive_inputs();
    repeat (6) cycle();
    check_val("rw_full_lvl", 64'(lv_a[3]), 64'd4);
    ro_mode[3] = 1;
    drive_inputs();
    cycle();
    check_val("rw_read_lvl", 64'(lv_a[3]), 64'd3);
    check_val("rw_read_ri", 64'(ri_a[3]), 64'd1);
    ro_mode[3] = 0;
    drive_inputs();
    cycle();
    check_val("rw_refill_lvl", 64'(lv_a[3]), 64'd4);
    ro_mode[3] = 1;
    drive_inputs();
    run_drain(30);
    compare_stream(3);

    // Wrap-around stream under random backpressure, plus random traffic elsewhere.
    for (int v = 0; v < 20; v++) send(1, 64'h1000 + 64'(v));
    for (int v = 0; v < 12; v++) begin
      send(4, {$urandom(), $urandom()});
      send(5, {$urandom(), $urandom()});
    end
    for (int v = 0; v < 8; v++) begin
      send(6, {$urandom(), $urandom()});
      send(7, {$urandom(), $urandom()});
    end
    ro_mode[1] = 2; ro_mode[4] = 2; ro_mode[5] = 2; ro_mode[6] = 2; ro_mode[7] = 2;
    drive_inputs();
    run_drain(600);
    for (int i = 0; i < NI; i++) ro_mode[i] = 1;
    drive_inputs();
    compare_stream(1);
    compare_stream(4);
    compare_stream(5);
    compare_stream(6);
    compare_stream(7);

    // Polarity gate on dut1: channel 0 stalled while channel 1 keeps flowing.
    ro_mode[6] = 0;
    for (int v = 0; v < 3; v++) send(6, 64'hA0 + 64'(v));
    for (int v = 0; v < 6; v++) send(7, 64'hB0 + 64'(v));
    drive_inputs();
    repeat (16) cycle();
    check_val("gate_stall_lvl", 64'(lv_a[6]), 64'd3);
    check_val("gate_other_cnt", 64'(rcv[7].size()), 64'd6);
    ro_mode[6] = 1;
    drive_inputs();
    first_k = -1;
    last_k  = -1;
    for (int k = 0; k < 20 && rcv[6].size() < 3; k++) begin
      sz = rcv[6].size();
      cycle();
      if (rcv[6].size() > sz) begin
        if (first_k < 0) first_k = k;
        last_k = k;
      end
    end
    check_val("gate_span", 64'(last_k - first_k), 64'd4);
    compare_stream(6);
    compare_stream(7);

    // Asynchronous reset in the middle of traffic.
    for (int v = 0; v < 10; v++) begin
      send(0, {$urandom(), $urandom()});
      send(5, {$urandom(), $urandom()});
      send(7, {$urandom(), $urandom()});
    end
    ro_mode[0] = 2; ro_mode[5] = 0; ro_mode[7] = 2;
    drive_inputs();
    repeat (6) cycle();
    #2 reset = 1'b0;
    #1;
    check_all_reset("async_rst");
    model_clear();
    for (int i = 0; i < NI; i++) begin
      src[i].delete();
      rcv[i].delete();
      exp_q[i].delete();
      ro_mode[i] = 1;
    end
    drive_inputs();
    repeat (2) cycle();
    reset = 1'b1;
    cycle();
    check_val("rerelease_ri0", 64'(ri0), 64'h3f);
    for (int v = 0; v < 10; v++) send(0, 64'h5000 + 64'(v));
    ro_mode[0] = 2;
    drive_inputs();
    run_drain(200);
    compare_stream(0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
